// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-main-memory arbiter.
// Request/response structs are the common cache <-> memory block transaction format.
package cache_mem_arbiter_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int WORD_WIDTH   = 32;
  localparam int BLOCK_SIZE   = 4;
  localparam int NUM_MEM_REQ  = 2;
  localparam int REQ_ID_WIDTH = $clog2(NUM_MEM_REQ);

  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cs;
    logic                  rw;
    block_t                data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Wrapping increment; n need not be a power of two.
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input int unsigned n);
    return (idx + 32'd1) % n;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first asserted request at or above rr_ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module cache_mem_arbiter_rr_priority_picker
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_MEM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [ID_W-1:0] cand_s;

  // Scan from the farthest offset down so the nearest hit to rr_ptr_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s  = ID_W'((32'(rr_ptr_i) + 32'(k)) % 32'(NUM_REQ));
      valid_o = valid_o | req_vec_i[cand_s];
      idx_o   = req_vec_i[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between icache (0) and dcache (1).
// Grant is held until memory acks, followed by one release cycle before re-arbitration.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_MEM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  memory_request_t    req_i [NUM_REQ],
  output memory_response_t   resp_o [NUM_REQ],
  output memory_request_t    mem_req_o,
  input  memory_response_t   mem_resp_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] grant_idx_q, grant_idx_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  memory_request_t shadow_q, shadow_d;
  logic            drop_q, drop_d;

  logic [NUM_REQ-1:0] req_cs_s;
  logic               pick_valid_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               granted_cs_s;
  logic               fwd_ack_s;

  always_comb begin
    req_cs_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cs_s[i] = req_i[i].cs;
    end
  end

  cache_mem_arbiter_rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_vec_i (req_cs_s),
    .rr_ptr_i  (rr_ptr_q),
    .valid_o   (pick_valid_s),
    .idx_o     (pick_idx_s)
  );

  // A requester that let go of cs mid-transaction must not see the ack.
  assign granted_cs_s = req_i[grant_idx_q].cs;
  assign fwd_ack_s    = (state_q == ARB_BUSY) && mem_resp_i.ack && !drop_q && granted_cs_s;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    shadow_d    = shadow_q;
    drop_d      = drop_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_d     = ARB_BUSY;
          grant_idx_d = pick_idx_s;
          shadow_d    = req_i[pick_idx_s];
          shadow_d.cs = 1'b1;
          drop_d      = 1'b0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (!granted_cs_s) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (mem_resp_i.ack) begin
          rr_ptr_d = ID_W'(rr_next(32'(grant_idx_q), NUM_REQ));
          state_d  = ARB_RELEASE;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      shadow_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      shadow_q    <= shadow_d;
      drop_q      <= drop_d;
    end
  end

  // Memory-side request comes from the grant-time capture, never from live inputs.
  always_comb begin
    mem_req_o = '0;
    grant_o   = '0;
    busy_o    = 1'b0;
    if (state_q == ARB_BUSY) begin
      mem_req_o            = shadow_q;
      mem_req_o.cs         = 1'b1;
      grant_o[grant_idx_q] = 1'b1;
      busy_o               = 1'b1;
    end else begin
      mem_req_o = '0;
      grant_o   = '0;
      busy_o    = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_o[i] = '0;
      if (fwd_ack_s && (grant_idx_q == ID_W'(i))) begin
        resp_o[i].ack  = 1'b1;
        resp_o[i].data = mem_resp_i.data;
      end else begin
        resp_o[i] = '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level owner/pointer model.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic             clk;
  logic             rst;
  memory_request_t  req [NREQ];
  memory_response_t resp [NREQ];
  memory_request_t  mem_req;
  memory_response_t mem_resp;
  logic [NREQ-1:0]  grant;
  logic             busy;

  int checks;
  int errors;

  int              m_owner;
  bit              m_release;
  int              m_ptr;
  bit              m_drop;
  memory_request_t m_cap;

  cache_mem_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .resp_o     (resp),
    .mem_req_o  (mem_req),
    .mem_resp_i (mem_resp),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_update();
    if (rst) begin
      m_owner = -1; m_release = 1'b0; m_ptr = 0; m_drop = 1'b0; m_cap = '0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner].cs) m_drop = 1'b1;
      if (mem_resp.ack) begin
        m_ptr     = (m_owner + 1) % NREQ;
        m_owner   = -1;
        m_release = 1'b1;
      end
    end else if (m_release) begin
      m_release = 1'b0;
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        int c;
        c = (m_ptr + off) % NREQ;
        if (m_owner < 0 && req[c].cs) begin
          m_owner = c; m_cap = req[c]; m_cap.cs = 1'b1; m_drop = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) req[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_reqs(); mem_resp = '0;
    tick(); tick(); #1;
    checks++;
    if ({busy, grant, mem_req.cs} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, grant, mem_req.cs});
    end
    checks++;
    if (mem_req !== '0) begin
      errors++; $display("FAIL reset_mem_req: got %h expected 0", mem_req);
    end
    checks++;
    if (resp[0] !== '0 || resp[1] !== '0) begin
      errors++; $display("FAIL reset_resp: got %h/%h expected 0", resp[0], resp[1]);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    block_t d;
    req[0].addr = 32'h0000_0100; req[0].rw = 1'b0; req[0].cs = 1'b1; req[0].data = '0;
    #1;
    checks++;
    if (mem_req.cs !== 1'b0) begin
      errors++; $display("FAIL read_latency: got cs=%b expected 0", mem_req.cs);
    end
    tick(); #1;
    checks++;
    if ({mem_req.cs, mem_req.rw, mem_req.addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
      errors++; $display("FAIL read_issue: got cs=%b rw=%b addr=%h expected 1 0 00000100", mem_req.cs, mem_req.rw, mem_req.addr);
    end
    checks++;
    if ({grant, busy} !== 3'b011) begin
      errors++; $display("FAIL read_grant: got %b expected 011", {grant, busy});
    end
    repeat (4) tick();
    d = {32'd1, 32'd2, 32'd3, 32'd4};
    mem_resp.ack = 1'b1; mem_resp.data = d; #1;
    checks++;
    if (resp[0].ack !== 1'b1 || resp[0].data !== d) begin
      errors++; $display("FAIL read_resp0: got ack=%b data=%h expected 1 %h", resp[0].ack, resp[0].data, d);
    end
    checks++;
    if (resp[1] !== '0) begin
      errors++; $display("FAIL read_resp1: got %h expected 0", resp[1]);
    end
    tick();
    mem_resp = '0; req[0].cs = 1'b0; #1;
    checks++;
    if ({busy, grant, mem_req.cs, resp[0].ack} !== 5'b00000) begin
      errors++; $display("FAIL read_release: got %b expected 00000", {busy, grant, mem_req.cs, resp[0].ack});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    req[0].addr = 32'h400; req[0].cs = 1'b1;
    req[1].addr = 32'h800; req[1].cs = 1'b1;
    tick(); #1;
    checks++;
    if (grant !== 2'b01 || mem_req.addr !== 32'h400) begin
      errors++; $display("FAIL b2b_first: got grant=%b addr=%h expected 01 00000400", grant, mem_req.addr);
    end
    mem_resp.ack = 1'b1; tick(); mem_resp.ack = 1'b0; #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL b2b_release: got grant=%b expected 00", grant);
    end
    tick(); #1;
    checks++;
    if ({grant, mem_req.cs} !== 3'b000) begin
      errors++; $display("FAIL b2b_idle_gap: got %b expected 000", {grant, mem_req.cs});
    end
    tick(); #1;
    checks++;
    if (grant !== 2'b10 || mem_req.addr !== 32'h800) begin
      errors++; $display("FAIL b2b_second: got grant=%b addr=%h expected 10 00000800", grant, mem_req.addr);
    end
    mem_resp.ack = 1'b1; tick(); mem_resp.ack = 1'b0; req[1].cs = 1'b0;
    tick(); tick(); #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL b2b_third: got grant=%b expected 01", grant);
    end
    mem_resp.ack = 1'b1; tick(); mem_resp.ack = 1'b0; clear_reqs();
    tick(); tick();
  endtask

  task automatic test_write_back();
    memory_request_t exp;
    exp.addr = 32'h0000_2040; exp.cs = 1'b1; exp.rw = 1'b1;
    exp.data = {32'hA, 32'hB, 32'hC, 32'hD};
    req[1] = exp;
    tick();
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (mem_req !== exp) begin
        errors++; $display("FAIL wb_fields: got %h expected %h", mem_req, exp);
      end
      checks++;
      if ({grant, busy} !== 3'b101) begin
        errors++; $display("FAIL wb_grant: got %b expected 101", {grant, busy});
      end
      tick();
    end
    mem_resp.ack = 1'b1; tick(); mem_resp.ack = 1'b0; clear_reqs();
    tick(); tick();
  endtask

  task automatic test_spurious_ack();
    mem_resp.ack = 1'b1; mem_resp.data = {$urandom, $urandom, $urandom, $urandom}; #1;
    checks++;
    if ({resp[0].ack, resp[1].ack, busy} !== 3'b000) begin
      errors++; $display("FAIL spurious_ack: got %b expected 000", {resp[0].ack, resp[1].ack, busy});
    end
    tick(); tick(); mem_resp = '0;
    req[0].addr = 32'h10; req[0].cs = 1'b1;
    req[1].addr = 32'h20; req[1].cs = 1'b1;
    tick(); #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL spurious_rr_ptr: got grant=%b expected 01", grant);
    end
    mem_resp.ack = 1'b1; tick(); mem_resp.ack = 1'b0; clear_reqs();
    tick(); tick();
  endtask

  task automatic test_cs_drop();
    req[0].addr = 32'h300; req[0].cs = 1'b1;
    tick(); tick(); tick();
    req[0].cs = 1'b0; req[0].addr = 32'hDEAD_0000; #1;
    checks++;
    if ({mem_req.cs, mem_req.addr} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL drop_hold: got cs=%b addr=%h expected 1 00000300", mem_req.cs, mem_req.addr);
    end
    tick();
    mem_resp.ack = 1'b1; mem_resp.data = {4{32'h5A5A_5A5A}}; #1;
    checks++;
    if (resp[0] !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_no_ack: got resp0=%h busy=%b expected 0 1", resp[0], busy);
    end
    tick(); mem_resp = '0; #1;
    checks++;
    if ({busy, grant} !== 3'b000) begin
      errors++; $display("FAIL drop_release: got %b expected 000", {busy, grant});
    end
    tick(); #1;
    checks++;
    if ({busy, mem_req.cs} !== 2'b00) begin
      errors++; $display("FAIL drop_idle: got %b expected 00", {busy, mem_req.cs});
    end
  endtask

  task automatic test_reset_busy();
    req[0].addr = 32'h500; req[0].cs = 1'b1;
    tick(); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstbusy_pre: got busy=%b expected 1", busy);
    end
    rst = 1'b1; tick(); rst = 1'b0; clear_reqs(); #1;
    checks++;
    if ({mem_req.cs, grant, busy} !== 4'b0000) begin
      errors++; $display("FAIL rstbusy_outputs: got %b expected 0000", {mem_req.cs, grant, busy});
    end
    req[0].cs = 1'b1; req[1].cs = 1'b1;
    tick(); #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL rstbusy_rr_ptr: got grant=%b expected 01", grant);
    end
    mem_resp.ack = 1'b1; tick(); mem_resp.ack = 1'b0; clear_reqs();
    tick(); tick();
  endtask

  task automatic test_random();
    memory_request_t  exp_mem;
    memory_response_t exp_resp [NREQ];
    logic [NREQ-1:0]  exp_grant;
    logic             exp_busy;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i].cs) begin
          if ($urandom_range(0, 9) == 0) req[i].cs = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i].cs = 1'b1; req[i].addr = $urandom; req[i].rw = 1'($urandom_range(0, 1));
          for (int w = 0; w < BLOCK_SIZE; w++) req[i].data[w] = $urandom;
        end
        if ($urandom_range(0, 15) == 0) req[i].addr = $urandom;
      end
      mem_resp.ack = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < BLOCK_SIZE; w++) mem_resp.data[w] = $urandom;
      #1;
      exp_mem = '0; exp_grant = '0; exp_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) exp_resp[i] = '0;
      if (m_owner >= 0) begin
        exp_mem = m_cap; exp_mem.cs = 1'b1;
        exp_grant = 2'b01 << m_owner; exp_busy = 1'b1;
        if (mem_resp.ack && !m_drop && req[m_owner].cs) begin
          exp_resp[m_owner].ack = 1'b1; exp_resp[m_owner].data = mem_resp.data;
        end
      end
      checks++;
      if (mem_req !== exp_mem) begin
        errors++; $display("FAIL rnd_mem_req cyc %0d: got %h expected %h", cyc, mem_req, exp_mem);
      end
      checks++;
      if ({grant, busy} !== {exp_grant, exp_busy}) begin
        errors++; $display("FAIL rnd_grant cyc %0d: got %b expected %b", cyc, {grant, busy}, {exp_grant, exp_busy});
      end
      for (int i = 0; i < NREQ; i++) begin
        checks++;
        if (resp[i] !== exp_resp[i]) begin
          errors++; $display("FAIL rnd_resp%0d cyc %0d: got %h expected %h", i, cyc, resp[i], exp_resp[i]);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_owner = -1; m_release = 1'b0; m_ptr = 0; m_drop = 1'b0; m_cap = '0;
    rst = 1'b1; mem_resp = '0;
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_back();
    test_spurious_ack();
    test_cs_drop();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
